pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It generalises the registered 16-bit CLA wrapper in four ways: configurable width, configurable lookahead block size, a configurable number of carry-segment pipeline stages, and an add/subtract mode with status flags. It sits in the datapath wherever a wide, timing-closed add/sub with backpressure is needed, for example in ALU and accumulator front-ends.

---
 rtl/pipelined_cla_addsub.sv | 209 ++++++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The word is split into STAGES segments of WIDTH/STAGES bits; each
// pipeline step resolves one segment with BLOCK-bit CLA blocks and a
// lookahead carry unit, then hands the carry to the next step.
// Legal only if WIDTH%STAGES==0 and (WIDTH/STAGES)%BLOCK==0.
module pipelined_cla_addsub #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned BLOCK  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             P,
   output logic             G
);

   localparam int unsigned SEG    = WIDTH / STAGES;
   localparam int unsigned NBLK   = SEG / BLOCK;
   localparam int unsigned WBLK   = WIDTH / BLOCK;

   // One segment: per-block group P/G, lookahead carries across blocks,
   // then per-bit sums inside each block from its block carry-in.
   function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           ci);
      logic [SEG-1:0]  p;
      logic [SEG-1:0]  g;
      logic [SEG-1:0]  s;
      logic [NBLK:0]   bc;
      logic            bp;
      logic            bg;
      logic            c;
      p     = x ^ y;
      g     = x & y;
      s     = '0;
      bc    = '0;
      bc[0] = ci;
      for (int unsigned blk = 0; blk < NBLK; blk++) begin
         bp = 1'b1;
         bg = 1'b0;
         for (int unsigned k = 0; k < BLOCK; k++) begin
            bg = g[blk*BLOCK+k] | (p[blk*BLOCK+k] & bg);
            bp = bp & p[blk*BLOCK+k];
         end
         bc[blk+1] = bg | (bp & bc[blk]);
      end
      for (int unsigned blk = 0; blk < NBLK; blk++) begin
         c = bc[blk];
         for (int unsigned k = 0; k < BLOCK; k++) begin
            s[blk*BLOCK+k] = p[blk*BLOCK+k] ^ c;
            c = g[blk*BLOCK+k] | (p[blk*BLOCK+k] & c);
         end
      end
      return {bc[NBLK], s};
   endfunction

   // Whole-word group propagate/generate built from BLOCK-bit groups.
   function automatic logic [1:0] group_pg(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
      logic gp;
      logic gg;
      logic bp;
      logic bg;
      gp = 1'b1;
      gg = 1'b0;
      for (int unsigned blk = 0; blk < WBLK; blk++) begin
         bp = 1'b1;
         bg = 1'b0;
         for (int unsigned k = 0; k < BLOCK; k++) begin
            bg = (x[blk*BLOCK+k] & y[blk*BLOCK+k]) |
                 ((x[blk*BLOCK+k] ^ y[blk*BLOCK+k]) & bg);
            bp = bp & (x[blk*BLOCK+k] ^ y[blk*BLOCK+k]);
         end
         gg = bg | (bp & gg);
         gp = gp & bp;
      end
      return {gp, gg};
   endfunction

   // Stage registers 0..STAGES-1: operands, partial sum, segment carry-in.
   logic [WIDTH-1:0] op_a  [0:STAGES-1];
   logic [WIDTH-1:0] op_b  [0:STAGES-1];
   logic [WIDTH-1:0] psum  [0:STAGES-1];
   logic [STAGES-1:0] c_q;
   // Valid bit per stage; bit STAGES is the output register.
   logic [STAGES:0]  v;
   // Operand copy feeding the P/G tree, and P/G bits for stages 1..STAGES.
   logic [WIDTH-1:0] pg_a;
   logic [WIDTH-1:0] pg_b;
   logic [STAGES-1:0] p_q;
   logic [STAGES-1:0] g_q;
   // Output register.
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [WIDTH-1:0] nsum  [0:STAGES-1];
   logic [STAGES-1:0] ncarry;
   logic [SEG:0]     seg_res;
   logic [1:0]       pg0;
   logic [STAGES:0]  p_chain;
   logic [STAGES:0]  g_chain;
   logic [WIDTH-1:0] fsum;
   logic             ovf_n;
   logic             zero_n;

   assign adv       = !v[STAGES] || out_ready;
   assign in_ready  = adv && !rst;
   assign b_eff     = sub ? ~b : b;
   assign c_eff     = sub | cin;
   assign pg0       = group_pg(pg_a, pg_b);
   assign fsum      = nsum[STAGES-1];
   assign ovf_n     = (op_a[STAGES-1][WIDTH-1] == op_b[STAGES-1][WIDTH-1]) &&
                      (fsum[WIDTH-1] != op_a[STAGES-1][WIDTH-1]);
   assign zero_n    = ~|fsum;

   assign out_valid = v[STAGES];
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign P         = p_q[STAGES-1];
   assign G         = g_q[STAGES-1];

   // Segment i adder: merges its CLA result into the partial sum for stage i+1.
   always_comb begin
      seg_res = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         seg_res   = cla_seg(op_a[i][i*SEG +: SEG], op_b[i][i*SEG +: SEG], c_q[i]);
         nsum[i]   = psum[i] | (WIDTH'(seg_res[SEG-1:0]) << (i*SEG));
         ncarry[i] = seg_res[SEG];
      end
   end

   // P/G sources per stage: stage 0 computes, later stages forward.
   always_comb begin
      p_chain = {p_q, pg0[1]};
      g_chain = {g_q, pg0[0]};
   end

   // Pipeline advance: all stages shift together when adv, hold otherwise;
   // data registers load only behind a valid beat so bubbles leave outputs alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         v      <= '0;
         c_q    <= '0;
         p_q    <= '0;
         g_q    <= '0;
         pg_a   <= '0;
         pg_b   <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            op_a[i] <= '0;
            op_b[i] <= '0;
            psum[i] <= '0;
         end
      end else if (adv) begin
         v <= {v[STAGES-1:0], in_valid};
         if (in_valid) begin
            op_a[0] <= a;
            op_b[0] <= b_eff;
            c_q[0]  <= c_eff;
            psum[0] <= '0;
            pg_a    <= a;
            pg_b    <= b_eff;
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (v[i-1]) begin
               op_a[i] <= op_a[i-1];
               op_b[i] <= op_b[i-1];
               psum[i] <= nsum[i-1];
               c_q[i]  <= ncarry[i-1];
            end
         end
         for (int unsigned i = 0; i < STAGES; i++) begin
            if (v[i]) begin
               p_q[i] <= p_chain[i];
               g_q[i] <= g_chain[i];
            end
         end
         if (v[STAGES-1]) begin
            sum_q  <= fsum;
            cout_q <= ncarry[STAGES-1];
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: a 16-bit/2-stage instance for directed cases and a
// 32-bit/4-stage instance for a random stream with random backpressure.
module tb_pipelined_cla_addsub;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        p;
      logic        g;
      int unsigned stamp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        out_valid16, out_ready16 = 1'b1, cout16, ovf16, zero16, p16, g16;

   logic        in_valid32 = 1'b0, in_ready32, cin32 = 1'b0, sub32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0, sum32;
   logic        out_valid32, out_ready32 = 1'b1, cout32, ovf32, zero32, p32, g32;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   exp_t        q16[$];
   exp_t        q32[$];
   int unsigned adv16 = 0, adv32 = 0;
   logic        hold16 = 1'b0, hold32 = 1'b0;
   logic [21:0] snap16 = '0;
   logic [37:0] snap32 = '0;

   always #5 clk = ~clk;

   pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16), .sub(sub16),
      .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
      .cout(cout16), .ovf(ovf16), .zero(zero16), .P(p16), .G(g16));

   pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32),
      .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
      .cout(cout32), .ovf(ovf32), .zero(zero32), .P(p32), .G(g32));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference arithmetic on a 64-bit scratch word, masked to w bits.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tc, input logic ts, input int unsigned w);
      exp_t        e;
      logic [63:0] mask, aa, bb, full, raw;
      mask    = (64'd1 << w) - 64'd1;
      aa      = {32'd0, ta} & mask;
      bb      = ts ? (~{32'd0, tb}) & mask : {32'd0, tb} & mask;
      full    = aa + bb + {63'd0, ts | tc};
      raw     = aa + bb;
      e.sum   = full[31:0] & mask[31:0];
      e.cout  = full[w];
      e.ovf   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
      e.zero  = ((full & mask) == 64'd0);
      e.p     = (((aa ^ bb) & mask) == mask);
      e.g     = raw[w];
      e.stamp = 0;
      return e;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0:       r = '0;
         1:       r = '1;
         2:       r = 32'h8000_0000;
         3:       r = 32'h7FFF_FFFF;
         default: r = $urandom();
      endcase
      return r;
   endfunction

   // Scoreboard for the 16-bit instance, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("rst_in_ready16", in_ready16, 0);
         q16.delete();
         hold16 = 1'b0;
      end else begin
         check("in_ready16", in_ready16, !out_valid16 || out_ready16);
         if (hold16)
            check("hold16", {out_valid16, sum16, cout16, ovf16, zero16, p16, g16}, snap16);
         if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) check("spurious16", 1, 0);
            else begin
               e = q16.pop_front();
               check("sum16",  sum16,  e.sum[15:0]);
               check("cout16", cout16, e.cout);
               check("ovf16",  ovf16,  e.ovf);
               check("zero16", zero16, e.zero);
               check("p16",    p16,    e.p);
               check("g16",    g16,    e.g);
               check("lat16",  adv16 - e.stamp, 2);
            end
         end
         if (!out_valid16 || out_ready16) adv16++;
         if (in_valid16 && in_ready16) begin
            e = model({16'd0, a16}, {16'd0, b16}, cin16, sub16, 16);
            e.stamp = adv16;
            q16.push_back(e);
         end
         hold16 = out_valid16 && !out_ready16;
         snap16 = {out_valid16, sum16, cout16, ovf16, zero16, p16, g16};
      end
   end

   // Scoreboard for the 32-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("rst_in_ready32", in_ready32, 0);
         q32.delete();
         hold32 = 1'b0;
      end else begin
         check("in_ready32", in_ready32, !out_valid32 || out_ready32);
         if (hold32)
            check("hold32", {out_valid32, sum32, cout32, ovf32, zero32, p32, g32}, snap32);
         if (out_valid32 && out_ready32) begin
            if (q32.size() == 0) check("spurious32", 1, 0);
            else begin
               e = q32.pop_front();
               check("sum32",  sum32,  e.sum);
               check("cout32", cout32, e.cout);
               check("ovf32",  ovf32,  e.ovf);
               check("zero32", zero32, e.zero);
               check("p32",    p32,    e.p);
               check("g32",    g32,    e.g);
               check("lat32",  adv32 - e.stamp, 4);
            end
         end
         if (!out_valid32 || out_ready32) adv32++;
         if (in_valid32 && in_ready32) begin
            e = model(a32, b32, cin32, sub32, 32);
            e.stamp = adv32;
            q32.push_back(e);
         end
         hold32 = out_valid32 && !out_ready32;
         snap32 = {out_valid32, sum32, cout32, ovf32, zero32, p32, g32};
      end
   end

   task automatic send16(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts);
      bit done = 1'b0;
      a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; in_valid16 = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         done = in_ready16;
         @(posedge clk); #1;
      end
      in_valid16 = 1'b0;
      if (!done) check("send16_timeout", 0, 1);
   endtask

   task automatic drain16();
      for (int n = 0; n < 50 && q16.size() != 0; n++) @(posedge clk);
      #1;
      check("drain16", q16.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned acc_n;
      bit          acc;
      int unsigned sent;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid16", out_valid16, 0);
      check("rst_outputs16", {sum16, cout16, ovf16, zero16, p16, g16}, 0);
      check("rst_out_valid32", out_valid32, 0);
      check("rst_outputs32", {sum32, cout32, ovf32, zero32, p32, g32}, 0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst16", in_ready16, 1);
      check("in_ready_after_rst32", in_ready32, 1);

      // Directed arithmetic cases
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send16(16'hAAAA, 16'h5555, 1'b1, 1'b0);
      send16(16'h0005, 16'h0007, 1'b1, 1'b1);
      send16(16'h8000, 16'h0001, 1'b0, 1'b1);
      send16(16'h0000, 16'h0000, 1'b0, 1'b1);
      send16(16'h1234, 16'h1234, 1'b0, 1'b1);
      drain16();

      // Backpressure: fill with out_ready low, then release
      out_ready16 = 1'b0;
      acc_n = 0;
      a16 = 16'd1; b16 = 16'd1; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         acc = in_valid16 && in_ready16;
         @(posedge clk); #1;
         if (acc) begin
            acc_n++;
            if (acc_n < 4) begin a16 = 16'(acc_n + 1); b16 = 16'(acc_n + 1); end
            else in_valid16 = 1'b0;
         end
      end
      check("bp_accepts", acc_n, 3);
      check("bp_in_ready", in_ready16, 0);
      check("bp_out_valid", out_valid16, 1);
      check("bp_held_sum", sum16, 16'h0002);
      out_ready16 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < 4) check("bp_stream_valid", out_valid16, 1);
         acc = in_valid16 && in_ready16;
         @(posedge clk); #1;
         if (acc) begin
            acc_n++;
            in_valid16 = 1'b0;
         end
      end
      check("bp_total_accepts", acc_n, 4);
      drain16();

      // Reset mid-flight
      send16(16'h0011, 16'h0022, 1'b0, 1'b0);
      send16(16'h0033, 16'h0044, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready16, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", out_valid16, 0);
      check("midrst_outputs", {sum16, cout16, ovf16, zero16, p16, g16}, 0);
      #1;
      check("midrst_in_ready_up", in_ready16, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("midrst_idle", out_valid16, 0);
      end

      // Random stream on the 32-bit / 4-stage instance
      @(posedge clk); #1;
      sent = 0;
      in_valid32 = ($urandom_range(0, 9) < 8);
      a32 = rnd_word(); b32 = rnd_word();
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      out_ready32 = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         @(negedge clk);
         acc = in_valid32 && in_ready32;
         @(posedge clk); #1;
         if (acc) sent++;
         out_ready32 = ($urandom_range(0, 9) < 7);
         if (!in_valid32 || acc) begin
            in_valid32 = (sent < 1000) && ($urandom_range(0, 9) < 8);
            a32 = rnd_word(); b32 = rnd_word();
            cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
         end
      end
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      check("rand_sent", sent, 1000);
      for (int n = 0; n < 100 && q32.size() != 0; n++) @(posedge clk);
      #1;
      check("drain32", q32.size(), 0);
      check("final_q16", q16.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
